// File: rtl/dest_rr_arbiter_if.sv
// dest_rr_arbiter_if
//   Bundles the two destination-FIFO read ports and the output sink
//   handshake seen by dest_rr_arbiter.
//
//   Signals
//     D0_data_out / D1_data_out : FIFO read data (word popped on the previous rd)
//     D0_empty    / D1_empty    : FIFO empty flags
//     D0_rd       / D1_rd       : FIFO pop strobes
//     data_out, valid_out       : registered output word and its valid flag
//     src_out                   : source of data_out (0 = D0, 1 = D1)
//     out_ready                 : sink accepts data_out this cycle
//
//   Modports
//     slave  : the arbiter (consumes FIFO data, drives the sink)
//     master : the environment (FIFOs and sink)
interface dest_rr_arbiter_if #(
    parameter int BW = 6
);
    logic [BW-1:0] D0_data_out;
    logic          D0_empty;
    logic [BW-1:0] D1_data_out;
    logic          D1_empty;
    logic          D0_rd;
    logic          D1_rd;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic          src_out;
    logic          out_ready;

    modport slave (
        input  D0_data_out, D0_empty, D1_data_out, D1_empty, out_ready,
        output D0_rd, D1_rd, data_out, valid_out, src_out
    );

    modport master (
        output D0_data_out, D0_empty, D1_data_out, D1_empty, out_ready,
        input  D0_rd, D1_rd, data_out, valid_out, src_out
    );
endinterface

// File: rtl/dest_rr_arbiter.sv
// dest_rr_arbiter
//   Merges the D0/D1 destination FIFOs into one output stream. Channels are
//   chosen round-robin, one word is fetched at a time into a registered
//   output slot, and the slot is emptied through a valid/ready handshake.
//   Per-destination counters record the words accepted by the sink.
//
//   Ports
//     clk        : clock, all logic on the rising edge
//     reset      : synchronous active-high reset
//     active_in  : new FIFO reads may only start while high
//     bus        : FIFO read ports and sink handshake (slave modport)
//     count_D0   : words from D0 accepted by the sink (wraps)
//     count_D1   : words from D1 accepted by the sink (wraps)
//     busy       : high whenever the FSM is not IDLE
module dest_rr_arbiter #(
    parameter int BW    = 6,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               active_in,
    dest_rr_arbiter_if.slave   bus,
    output logic [CNT_W-1:0]   count_D0,
    output logic [CNT_W-1:0]   count_D1,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        LOAD,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_q, grant_d;
    logic               d0_rd_q, d0_rd_d;
    logic               d1_rd_q, d1_rd_d;
    logic [BW-1:0]      data_q, data_d;
    logic               valid_q, valid_d;
    logic               src_q, src_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic               cand0, cand1, any_cand, pick, handshake;

    // Round-robin pick: a lone candidate always wins; on a tie the channel
    // that did not win last time is chosen.
    assign cand0     = ~bus.D0_empty;
    assign cand1     = ~bus.D1_empty;
    assign any_cand  = cand0 | cand1;
    assign pick      = (cand0 & cand1) ? ~last_grant_q : cand1;
    assign handshake = valid_q & bus.out_ready;

    // Next-state logic. Empty flags are only looked at in IDLE and in HOLD
    // on a handshake, i.e. when no read is in flight, so a FIFO whose pop is
    // still travelling through ISSUE/LOAD can never be popped twice.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        d0_rd_d      = 1'b0;
        d1_rd_d      = 1'b0;
        data_d       = data_q;
        valid_d      = valid_q;
        src_d        = src_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;

        unique case (state_q)
            IDLE: begin
                if (active_in && any_cand) begin
                    state_d      = ISSUE;
                    grant_d      = pick;
                    last_grant_d = pick;
                    d0_rd_d      = ~pick;
                    d1_rd_d      = pick;
                end
            end
            ISSUE: begin
                state_d = LOAD;
            end
            LOAD: begin
                data_d  = grant_q ? bus.D1_data_out : bus.D0_data_out;
                src_d   = grant_q;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (handshake) begin
                    if (src_q) begin
                        cnt1_d = cnt1_q + 1'b1;
                    end else begin
                        cnt0_d = cnt0_q + 1'b1;
                    end
                    valid_d = 1'b0;
                    if (active_in && any_cand) begin
                        state_d      = ISSUE;
                        grant_d      = pick;
                        last_grant_d = pick;
                        d0_rd_d      = ~pick;
                        d1_rd_d      = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. last_grant resets to D1 so that D0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            d0_rd_q      <= 1'b0;
            d1_rd_q      <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            src_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            d0_rd_q      <= d0_rd_d;
            d1_rd_q      <= d1_rd_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            src_q        <= src_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.D0_rd     = d0_rd_q;
    assign bus.D1_rd     = d1_rd_q;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.src_out   = src_q;
    assign count_D0      = cnt0_q;
    assign count_D1      = cnt1_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dest_rr_arbiter.sv
// tb_dest_rr_arbiter
//   Drives dest_rr_arbiter from two queue-based FIFO models and a sink with
//   directed scenarios and a randomized run. A transaction-level model
//   (grant -> word arrives two edges later -> held until accepted) predicts
//   every output each cycle; directed scenarios add hand-computed literals.
module tb_dest_rr_arbiter;

    localparam int BW    = 6;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             active_in;
    logic [CNT_W-1:0] count_D0;
    logic [CNT_W-1:0] count_D1;
    logic             busy;

    dest_rr_arbiter_if #(.BW(BW)) bus ();

    dest_rr_arbiter #(.BW(BW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .active_in(active_in),
        .bus      (bus),
        .count_D0 (count_D0),
        .count_D1 (count_D1),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;
    int underflow   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO models: the pop happens on the edge that samples rd, the popped
    // word is presented the following cycle, and the empty flag is registered.
    logic [BW-1:0] fifo0[$];
    logic [BW-1:0] fifo1[$];
    logic [BW-1:0] exp0[$];
    logic [BW-1:0] exp1[$];
    logic [BW-1:0] popTmp;

    always @(posedge clk) begin
        if (reset) begin
            fifo0.delete();
            fifo1.delete();
            bus.D0_empty    <= 1'b1;
            bus.D1_empty    <= 1'b1;
            bus.D0_data_out <= '0;
            bus.D1_data_out <= '0;
        end else begin
            if (bus.D0_rd) begin
                if (fifo0.size() > 0) begin
                    popTmp = fifo0.pop_front();
                    bus.D0_data_out <= popTmp;
                end else begin
                    underflow++;
                end
            end
            if (bus.D1_rd) begin
                if (fifo1.size() > 0) begin
                    popTmp = fifo1.pop_front();
                    bus.D1_data_out <= popTmp;
                end else begin
                    underflow++;
                end
            end
            bus.D0_empty <= (fifo0.size() == 0);
            bus.D1_empty <= (fifo1.size() == 0);
        end
    end

    // Transaction-level reference: a word is granted, travels for two edges,
    // then sits in the output slot until the sink takes it.
    bit            modelReady = 0;
    bit            mInFlight, mHolding, mCh, mLastG, mSrc;
    int            mAge;
    logic [BW-1:0] mPend, mData;
    int            mCnt0, mCnt1;
    bit            mDeliv, mCanGrant, mC0, mC1, mG;

    always @(posedge clk) begin
        if (reset) begin
            mInFlight = 0; mHolding = 0; mCh = 0; mLastG = 1; mSrc = 0;
            mAge = 0; mPend = '0; mData = '0; mCnt0 = 0; mCnt1 = 0;
            exp0.delete();
            exp1.delete();
            modelReady = 1;
        end else begin
            mDeliv    = mHolding && bus.out_ready;
            mCanGrant = (!mInFlight && !mHolding) || mDeliv;
            if (mDeliv) begin
                if (mSrc) mCnt1 = (mCnt1 + 1) % (1 << CNT_W);
                else      mCnt0 = (mCnt0 + 1) % (1 << CNT_W);
                mHolding = 0;
            end
            if (mInFlight) begin
                mAge++;
                if (mAge == 2) begin
                    mInFlight = 0;
                    mHolding  = 1;
                    mData     = mPend;
                    mSrc      = mCh;
                end
            end
            mC0 = !bus.D0_empty;
            mC1 = !bus.D1_empty;
            if (mCanGrant && active_in && (mC0 || mC1)) begin
                mG        = (mC0 && mC1) ? !mLastG : mC1;
                mLastG    = mG;
                mCh       = mG;
                mInFlight = 1;
                mAge      = 0;
                mPend     = '0;
                if (mG && exp1.size() > 0)       mPend = exp1.pop_front();
                else if (!mG && exp0.size() > 0) mPend = exp0.pop_front();
            end
        end
    end

    // Per-cycle comparison plus a log of every accepted word.
    logic [BW-1:0] logData[$];
    bit            logSrc[$];
    int            logCyc[$];
    int            rd0Pulses = 0;
    int            rd1Pulses = 0;
    bit            armStart  = 0;
    int            startCyc  = 0;

    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("D0_rd", bus.D0_rd, mInFlight && mAge == 0 && !mCh);
            checkOutput("D1_rd", bus.D1_rd, mInFlight && mAge == 0 && mCh);
            checkOutput("valid_out", bus.valid_out, mHolding);
            checkOutput("busy", busy, mInFlight || mHolding);
            checkOutput("count_D0", count_D0, mCnt0);
            checkOutput("count_D1", count_D1, mCnt1);
            checkOutput("no_overread", underflow, 0);
            if (mHolding) begin
                checkOutput("data_out", bus.data_out, mData);
                checkOutput("src_out", bus.src_out, mSrc);
            end
            if (bus.D0_rd) rd0Pulses++;
            if (bus.D1_rd) rd1Pulses++;
            if (armStart && (!bus.D0_empty || !bus.D1_empty)) begin
                startCyc = cyc;
                armStart = 0;
            end
            if (!reset && bus.valid_out && bus.out_ready) begin
                logData.push_back(bus.data_out);
                logSrc.push_back(bus.src_out);
                logCyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input bit ch, input logic [BW-1:0] word);
        if (ch) begin
            fifo1.push_back(word);
            exp1.push_back(word);
        end else begin
            fifo0.push_back(word);
            exp0.push_back(word);
        end
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic waitDrain(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            if (fifo0.size() == 0 && fifo1.size() == 0 && bus.D0_empty &&
                bus.D1_empty && !busy) done = 1;
            else tick(1);
        end
        checkOutput("drain_within_budget", done, 1);
    endtask

    task automatic waitValid(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            if (bus.valid_out) done = 1;
            else tick(1);
        end
        checkOutput("valid_within_budget", done, 1);
    endtask

    task automatic waitRd0(input int budget);
        bit done = 0;
        for (int k = 0; k < budget && !done; k++) begin
            if (bus.D0_rd) done = 1;
            else tick(1);
        end
        checkOutput("rd_within_budget", done, 1);
    endtask

    initial begin
        logic [BW-1:0] fairExp[8];
        int            r0, r1, c0, c1, L;

        fairExp = '{6'h10, 6'h20, 6'h11, 6'h21, 6'h12, 6'h22, 6'h13, 6'h23};

        reset         = 1'b1;
        active_in     = 1'b0;
        bus.out_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        $display("[TB] reset state");
        checkOutput("reset_valid", bus.valid_out, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rd", {bus.D0_rd, bus.D1_rd}, 0);
        checkOutput("reset_data", bus.data_out, 0);
        checkOutput("reset_cnt", {count_D0, count_D1}, 0);

        $display("[TB] single channel");
        active_in     = 1'b1;
        bus.out_ready = 1'b1;
        armStart      = 1;
        applyStimulus(0, 6'h01);
        applyStimulus(0, 6'h02);
        applyStimulus(0, 6'h03);
        waitDrain(60);
        checkOutput("single_len", logData.size(), 3);
        if (logData.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput("single_data", logData[i], i + 1);
                checkOutput("single_src", logSrc[i], 0);
            end
            checkOutput("single_latency", logCyc[0] - startCyc, 3);
            checkOutput("single_period1", logCyc[1] - logCyc[0], 3);
            checkOutput("single_period2", logCyc[2] - logCyc[1], 3);
        end
        checkOutput("single_cnt0", count_D0, 3);
        checkOutput("single_cnt1", count_D1, 0);
        checkOutput("single_no_d1_rd", rd1Pulses, 0);

        $display("[TB] fairness");
        doReset(2);
        logData.delete(); logSrc.delete(); logCyc.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 6'h10 + 6'(i));
            applyStimulus(1, 6'h20 + 6'(i));
        end
        waitDrain(100);
        checkOutput("fair_len", logData.size(), 8);
        if (logData.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput("fair_data", logData[i], fairExp[i]);
                checkOutput("fair_src", logSrc[i], i % 2);
            end
        end
        checkOutput("fair_cnt0", count_D0, 4);
        checkOutput("fair_cnt1", count_D1, 4);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(0, 6'h05);
        applyStimulus(1, 6'h06);
        waitValid(20);
        r0 = rd0Pulses; r1 = rd1Pulses; c0 = count_D0; c1 = count_D1;
        tick(10);
        checkOutput("bp_no_rd", (rd0Pulses + rd1Pulses) - (r0 + r1), 0);
        checkOutput("bp_data", bus.data_out, 6'h05);
        checkOutput("bp_src", bus.src_out, 0);
        checkOutput("bp_valid", bus.valid_out, 1);
        checkOutput("bp_cnt_stable", {count_D0, count_D1}, {8'(c0), 8'(c1)});
        bus.out_ready = 1'b1;
        tick(1);
        checkOutput("bp_cnt0_inc", count_D0, c0 + 1);
        checkOutput("bp_cnt1_same", count_D1, c1);
        waitDrain(40);

        $display("[TB] active_in drop");
        for (int i = 0; i < 5; i++) applyStimulus(0, 6'h30 + 6'(i));
        waitRd0(20);
        active_in = 1'b0;
        L  = logData.size();
        r0 = rd0Pulses + rd1Pulses;
        tick(15);
        checkOutput("drop_one_rd", (rd0Pulses + rd1Pulses) - r0, 1);
        checkOutput("drop_one_word", logData.size() - L, 1);
        if (logData.size() > 0) checkOutput("drop_word", logData[$], 6'h30);
        checkOutput("drop_idle", busy, 0);
        active_in = 1'b1;
        waitDrain(100);
        checkOutput("resume_len", logData.size() - L, 5);
        if (logData.size() > 0) checkOutput("resume_last", logData[$], 6'h34);

        $display("[TB] counter wrap");
        doReset(2);
        for (int i = 0; i < 257; i++) applyStimulus(1, 6'(i));
        waitDrain(1200);
        checkOutput("wrap_cnt1", count_D1, 1);
        checkOutput("wrap_cnt0", count_D0, 0);
        checkOutput("wrap_no_overread", underflow, 0);

        $display("[TB] randomized traffic");
        doReset(2);
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    if (fifo0.size() < 8) applyStimulus(0, 6'($urandom));
                end else begin
                    if (fifo1.size() < 8) applyStimulus(1, 6'($urandom));
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            active_in     = ($urandom_range(0, 15) != 0);
            tick(1);
        end
        bus.out_ready = 1'b1;
        active_in     = 1'b1;
        waitDrain(200);

        $display("[TB] reset during HOLD");
        bus.out_ready = 1'b0;
        applyStimulus(1, 6'h2A);
        waitValid(20);
        reset = 1'b1;
        tick(2);
        checkOutput("rst_hold_valid", bus.valid_out, 0);
        checkOutput("rst_hold_busy", busy, 0);
        checkOutput("rst_hold_rd", {bus.D0_rd, bus.D1_rd}, 0);
        checkOutput("rst_hold_cnt", {count_D0, count_D1}, 0);
        reset = 1'b0;
        tick(1);
        checkOutput("post_rst_valid", bus.valid_out, 0);
        checkOutput("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
